// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter serialising icache/dcache line accesses onto one memory port
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     icache_mem_req,
  input  logic [ADDRESS_WIDTH-1:0] icache_mem_addr,
  output logic [LINE_WIDTH-1:0]    icache_mem_data,
  output logic                     icache_mem_ready,
  input  logic                     dcache_mem_req,
  input  logic                     dcache_mem_op,
  input  logic [ADDRESS_WIDTH-1:0] dcache_mem_addr,
  input  logic [LINE_WIDTH-1:0]    dcache_mem_wdata,
  output logic [LINE_WIDTH-1:0]    dcache_mem_data,
  output logic                     dcache_mem_ready,
  output logic                     mem_req,
  output logic                     mem_op,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0]    mem_wdata,
  input  logic [LINE_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t state, state_next;
  logic   last_grant;  // 1 = dcache won the most recent grant
  logic   pick_d;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pick_d     = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        pick_d = dcache_mem_req && (!icache_mem_req || !last_grant);
        if (pick_d)              state_next = GRANT_D;
        else if (icache_mem_req) state_next = GRANT_I;
      end
      GRANT_I: if (mem_ready) state_next = RESP_I;
      GRANT_D: if (mem_ready) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant       <= 1'b0;
      mem_req          <= 1'b0;
      mem_op           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      icache_mem_ready <= 1'b0;
      dcache_mem_ready <= 1'b0;
      icache_mem_data  <= '0;
      dcache_mem_data  <= '0;
    end else begin
      mem_req          <= (state_next == GRANT_I) || (state_next == GRANT_D);
      icache_mem_ready <= (state_next == RESP_I);
      dcache_mem_ready <= (state_next == RESP_D);

      if (state == IDLE && state_next == GRANT_I) begin
        last_grant <= 1'b0;
        mem_op     <= 1'b0;
        mem_addr   <= icache_mem_addr;
        mem_wdata  <= '0;
      end
      if (state == IDLE && state_next == GRANT_D) begin
        last_grant <= 1'b1;
        mem_op     <= dcache_mem_op;
        mem_addr   <= dcache_mem_addr;
        mem_wdata  <= dcache_mem_wdata;
      end

      if (state == GRANT_I && mem_ready)
        icache_mem_data <= mem_rdata;
      // Write completions leave the dcache read line untouched.
      if (state == GRANT_D && mem_ready && !mem_op)
        dcache_mem_data <= mem_rdata;
    end
  end

endmodule
